// File: rtl/trace_seq_pkg.sv
// Shared constants for the trace step sequencer: FSM state codes and the
// default machine-state vector width.
package trace_seq_pkg;

    localparam int STATE_W_DEFAULT = 1455;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FILL   = 3'd1;
    localparam logic [2:0] ST_ACCEPT = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/trace_step_sequencer_stats.sv
// Saturating per-run statistics: transitions checked, failing transitions,
// and the index of the first failing transition.
module trace_fail_stats
    import trace_seq_pkg::*;
#(
    parameter int STEP_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              sample,
    input  logic              result,
    output logic [STEP_W-1:0] steps_checked,
    output logic [STEP_W-1:0] steps_next,
    output logic [STEP_W-1:0] fail_count,
    output logic [STEP_W-1:0] first_fail_step,
    output logic              first_fail_valid
);

    localparam logic [STEP_W-1:0] ALL_ONES = {STEP_W{1'b1}};

    // Saturating successor of the step counter, also used for the limit compare.
    always_comb begin
        if (steps_checked == ALL_ONES) begin
            steps_next = steps_checked;
        end else begin
            steps_next = steps_checked + STEP_W'(1);
        end
    end

    // Statistics registers, cleared at run start and updated once per sampled verdict.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            steps_checked    <= '0;
            fail_count       <= '0;
            first_fail_step  <= '0;
            first_fail_valid <= 1'b0;
        end else if (sample) begin
            steps_checked <= steps_next;
            if (!result) begin
                if (fail_count != ALL_ONES) begin
                    fail_count <= fail_count + STEP_W'(1);
                end
                if (!first_fail_valid) begin
                    first_fail_step  <= steps_checked;
                    first_fail_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/trace_step_sequencer.sv
// Feeds consecutive pairs of a state-vector stream to an external single-step
// transition checker and accumulates the pass/fail verdicts of the whole trace.
module trace_step_sequencer
    import trace_seq_pkg::*;
#(
    parameter int STATE_W   = STATE_W_DEFAULT,
    parameter int STEP_W    = 32,
    parameter int CHECK_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STEP_W-1:0]  num_steps,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic               in_last,
    output logic [STATE_W-1:0] chk_current,
    output logic [STATE_W-1:0] chk_next,
    input  logic               chk_result,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [STEP_W-1:0]  steps_checked,
    output logic [STEP_W-1:0]  fail_count,
    output logic [STEP_W-1:0]  first_fail_step,
    output logic               first_fail_valid
);

    logic [2:0]         state_r;
    logic [STATE_W-1:0] cur_r;
    logic [STATE_W-1:0] nxt_r;
    logic               last_r;
    logic               pass_r;
    logic [STEP_W-1:0]  limit_r;
    logic [3:0]         cnt_r;

    logic               clear_s;
    logic               sample_s;
    logic               sample_last_s;
    logic               limit_hit_s;
    logic               finish_s;
    logic               pass_next_s;
    logic [STEP_W-1:0]  steps_next_s;

    assign in_ready    = (state_r == ST_FILL) || (state_r == ST_ACCEPT);
    assign busy        = in_ready || (state_r == ST_WAIT);
    assign done        = (state_r == ST_DONE);
    assign pass        = pass_r;
    assign chk_current = cur_r;
    // Zero latency samples in the accept cycle, so the checker must see the incoming state directly.
    assign chk_next    = ((CHECK_LAT == 0) && (state_r == ST_ACCEPT)) ? in_state : nxt_r;

    // Verdict sampling point and end-of-run decision.
    always_comb begin
        clear_s = (state_r == ST_IDLE) && start;
        case (state_r)
            ST_ACCEPT: sample_s = (CHECK_LAT == 0) && in_valid;
            ST_WAIT:   sample_s = (cnt_r <= 4'd1);
            default:   sample_s = 1'b0;
        endcase
        sample_last_s = (CHECK_LAT == 0) ? in_last : last_r;
        limit_hit_s   = (limit_r != '0) && (steps_next_s == limit_r);
        finish_s      = sample_s && (sample_last_s || limit_hit_s);
        pass_next_s   = (fail_count == '0) && chk_result;
    end

    // Run control FSM and the cur/nxt state-vector pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cur_r   <= '0;
            nxt_r   <= '0;
            last_r  <= 1'b0;
            pass_r  <= 1'b0;
            limit_r <= '0;
            cnt_r   <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        limit_r <= num_steps;
                        pass_r  <= 1'b0;
                        state_r <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (in_valid) begin
                        cur_r <= in_state;
                        if (in_last) begin
                            pass_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_ACCEPT;
                        end
                    end
                end
                ST_ACCEPT: begin
                    if (in_valid) begin
                        nxt_r  <= in_state;
                        last_r <= in_last;
                        if (CHECK_LAT == 0) begin
                            cur_r <= in_state;
                            if (finish_s) begin
                                pass_r  <= pass_next_s;
                                state_r <= ST_DONE;
                            end
                        end else begin
                            cnt_r   <= 4'(CHECK_LAT);
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (sample_s) begin
                        cur_r <= nxt_r;
                        if (finish_s) begin
                            pass_r  <= pass_next_s;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_ACCEPT;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    trace_fail_stats #(
        .STEP_W (STEP_W)
    ) u_stats (
        .clk              (clk),
        .rst              (rst),
        .clear            (clear_s),
        .sample           (sample_s),
        .result           (chk_result),
        .steps_checked    (steps_checked),
        .steps_next       (steps_next_s),
        .fail_count       (fail_count),
        .first_fail_step  (first_fail_step),
        .first_fail_valid (first_fail_valid)
    );

endmodule

// File: tb/tb_trace_step_sequencer.sv
// Self-checking bench: two sequencers (CHECK_LAT=0 and 1) driving a checker stub,
// with results compared against a trace-level reference model.
module tb_trace_step_sequencer;

    localparam int SW = 64;
    localparam int TW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, in_valid, in_last, sel;
    logic [TW-1:0] num_steps;
    logic [SW-1:0] in_state;

    logic          in_ready0, busy0, done0, pass0, ffv0, res0;
    logic          in_ready1, busy1, done1, pass1, ffv1, res1;
    logic [TW-1:0] steps0, fails0, ffs0, steps1, fails1, ffs1;
    logic [SW-1:0] cur0, nxt0, cur1, nxt1;

    logic          m_in_ready, m_busy, m_done, m_pass, m_ffv;
    logic [TW-1:0] m_steps, m_fails, m_ffs;
    logic [SW-1:0] m_cur, m_nxt;

    int errors = 0;
    int checks = 0;
    logic [SW-1:0] states[$];
    int got_dcyc, got_consumed;
    int exp_steps, exp_fails, exp_first, exp_dcyc, exp_consumed;
    bit exp_ffv, exp_pass;

    // Checker stub: a step is legal when the index advances by one and the new state is not flagged bad.
    function automatic logic verdict(input logic [SW-1:0] c, input logic [SW-1:0] n);
        return (n[31:0] == c[31:0] + 32'd1) && !n[63];
    endfunction

    assign res0 = verdict(cur0, nxt0);
    assign res1 = verdict(cur1, nxt1);

    assign m_in_ready = sel ? in_ready1 : in_ready0;
    assign m_busy     = sel ? busy1 : busy0;
    assign m_done     = sel ? done1 : done0;
    assign m_pass     = sel ? pass1 : pass0;
    assign m_ffv      = sel ? ffv1 : ffv0;
    assign m_steps    = sel ? steps1 : steps0;
    assign m_fails    = sel ? fails1 : fails0;
    assign m_ffs      = sel ? ffs1 : ffs0;
    assign m_cur      = sel ? cur1 : cur0;
    assign m_nxt      = sel ? nxt1 : nxt0;

    trace_step_sequencer #(.STATE_W(SW), .STEP_W(TW), .CHECK_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start && !sel), .num_steps(num_steps),
        .in_valid(in_valid && !sel), .in_ready(in_ready0), .in_state(in_state), .in_last(in_last),
        .chk_current(cur0), .chk_next(nxt0), .chk_result(res0), .busy(busy0), .done(done0),
        .pass(pass0), .steps_checked(steps0), .fail_count(fails0), .first_fail_step(ffs0),
        .first_fail_valid(ffv0));

    trace_step_sequencer #(.STATE_W(SW), .STEP_W(TW), .CHECK_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start && sel), .num_steps(num_steps),
        .in_valid(in_valid && sel), .in_ready(in_ready1), .in_state(in_state), .in_last(in_last),
        .chk_current(cur1), .chk_next(nxt1), .chk_result(res1), .busy(busy1), .done(done1),
        .pass(pass1), .steps_checked(steps1), .fail_count(fails1), .first_fail_step(ffs1),
        .first_fail_valid(ffv1));

    task automatic build(input int n, input int pct);
        states.delete();
        for (int i = 0; i < n; i++) begin
            logic [SW-1:0] v;
            v[31:0]  = 32'(i);
            v[62:32] = 31'($urandom);
            v[63]    = ($urandom_range(99) < pct);
            states.push_back(v);
        end
    endtask

    task automatic set_bad(input int i);
        logic [SW-1:0] v;
        v = states[i];
        v[63] = 1'b1;
        states[i] = v;
    endtask

    // Reference model: verdicts per transition of the trace, truncated by the step limit.
    task automatic model(input bit s, input int lim);
        int n_tr, fails;
        n_tr = states.size() - 1;
        if (lim != 0 && lim < n_tr) n_tr = lim;
        fails = 0; exp_ffv = 1'b0; exp_first = 0;
        for (int i = 0; i < n_tr; i++) begin
            if (!verdict(states[i], states[i+1])) begin
                if (!exp_ffv) begin
                    exp_first = (i > 255) ? 255 : i;
                    exp_ffv = 1'b1;
                end
                fails++;
            end
        end
        exp_fails    = (fails > 255) ? 255 : fails;
        exp_steps    = (n_tr > 255) ? 255 : n_tr;
        exp_pass     = (fails == 0);
        exp_consumed = n_tr + 1;
        exp_dcyc     = 2 + n_tr * (s ? 2 : 1);
    endtask

    task automatic run_trace(input bit s, input int lim, input bit gaps, input bit hold_start,
                             input int rst_wait, output bit aborted);
        int idx, cyc, waits, n;
        bit hs, seen_done;
        n = states.size();
        sel = s; in_valid = 1'b0;
        @(negedge clk);
        num_steps = TW'(lim); start = 1'b1;
        idx = 0; cyc = 0; hs = 1'b0; waits = 0; aborted = 1'b0; seen_done = 1'b0; got_dcyc = -1;
        for (int t = 0; t < 3000 && !seen_done && !aborted; t++) begin
            @(posedge clk);
            if (hs) idx++;
            @(negedge clk);
            cyc++;
            start = hold_start;
            if (m_done) begin
                seen_done = 1'b1; got_dcyc = cyc; start = 1'b0; in_valid = 1'b0;
            end else begin
                if (idx < n) begin
                    in_state = states[idx];
                    in_last  = (idx == n - 1);
                    in_valid = !gaps || (cyc % 2 == 1);
                end else begin
                    in_state = '0; in_last = 1'b0; in_valid = 1'b0;
                end
                #1;
                hs = in_valid && m_in_ready;
                if (m_busy && !m_in_ready) begin
                    waits++;
                    checks++;
                    if (m_cur !== states[idx-2] || m_nxt !== states[idx-1]) begin
                        errors++;
                        $display("FAIL wait_pair: got cur=%h nxt=%h expected cur=%h nxt=%h",
                                 m_cur, m_nxt, states[idx-2], states[idx-1]);
                    end
                    if (waits == rst_wait) begin
                        rst = 1'b1; aborted = 1'b1; hs = 1'b0;
                    end
                end
                if (!s && hs && idx > 0) begin
                    checks++;
                    if (m_cur !== states[idx-1] || m_nxt !== states[idx]) begin
                        errors++;
                        $display("FAIL bypass_pair: got cur=%h nxt=%h expected cur=%h nxt=%h",
                                 m_cur, m_nxt, states[idx-1], states[idx]);
                    end
                end
            end
        end
        in_valid = 1'b0; start = 1'b0;
        got_consumed = idx;
        if (!seen_done && !aborted) begin
            checks++; errors++;
            $display("FAIL run_timeout: got no done expected done within budget");
        end
        model(s, lim);
    endtask

    task automatic test_reset;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if ({m_in_ready, m_busy, m_done, m_pass, m_ffv} !== 5'b0) begin
                errors++; $display("FAIL reset_flags: got %b expected 00000", {m_in_ready, m_busy, m_done, m_pass, m_ffv});
            end
            checks++;
            if ({m_steps, m_fails, m_ffs} !== 24'h0 || m_cur !== '0 || m_nxt !== '0) begin
                errors++; $display("FAIL reset_values: got steps=%0d fails=%0d ffs=%0d cur=%h nxt=%h expected all 0",
                                   m_steps, m_fails, m_ffs, m_cur, m_nxt);
            end
        end
    endtask

    task automatic test_all_pass;
        bit ab;
        build(4, 0);
        run_trace(1'b1, 0, 1'b0, 1'b0, 0, ab);
        checks++; if (got_dcyc !== 8) begin errors++; $display("FAIL allpass_done_cycle: got %0d expected 8", got_dcyc); end
        checks++; if (m_pass !== 1'b1) begin errors++; $display("FAIL allpass_pass: got %b expected 1", m_pass); end
        checks++; if (int'(m_fails) !== 0 || m_ffv !== 1'b0) begin errors++; $display("FAIL allpass_fails: got %0d/%b expected 0/0", m_fails, m_ffv); end
        checks++; if (int'(m_steps) !== 3) begin errors++; $display("FAIL allpass_steps: got %0d expected 3", m_steps); end
        @(negedge clk); #1;
        checks++; if (m_done !== 1'b0 || m_pass !== 1'b1) begin errors++; $display("FAIL allpass_after_done: got done=%b pass=%b expected 0/1", m_done, m_pass); end
    endtask

    task automatic test_fail_pattern;
        bit ab;
        build(6, 0);
        set_bad(2);
        set_bad(3);
        run_trace(1'b1, 0, 1'b0, 1'b0, 0, ab);
        checks++; if (int'(m_fails) !== 2) begin errors++; $display("FAIL pattern_fails: got %0d expected 2", m_fails); end
        checks++; if (int'(m_ffs) !== 1 || m_ffv !== 1'b1) begin errors++; $display("FAIL pattern_first: got %0d/%b expected 1/1", m_ffs, m_ffv); end
        checks++; if (m_pass !== 1'b0 || int'(m_steps) !== 5) begin errors++; $display("FAIL pattern_pass_steps: got %b/%0d expected 0/5", m_pass, m_steps); end
    endtask

    task automatic test_step_limit;
        bit ab;
        build(10, 0);
        run_trace(1'b1, 2, 1'b0, 1'b0, 0, ab);
        checks++; if (got_consumed !== 3) begin errors++; $display("FAIL limit_consumed: got %0d expected 3", got_consumed); end
        checks++; if (int'(m_steps) !== 2 || got_dcyc !== 6) begin errors++; $display("FAIL limit_steps_cycle: got %0d/%0d expected 2/6", m_steps, got_dcyc); end
        checks++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL limit_ready_done: got %b expected 0", m_in_ready); end
        @(negedge clk); #1;
        checks++; if (m_in_ready !== 1'b0 || m_busy !== 1'b0) begin errors++; $display("FAIL limit_ready_idle: got %b/%b expected 0/0", m_in_ready, m_busy); end
    endtask

    task automatic test_single;
        bit ab;
        build(1, 0);
        run_trace(1'b1, 0, 1'b0, 1'b0, 0, ab);
        checks++; if (got_dcyc !== 2) begin errors++; $display("FAIL single_done_cycle: got %0d expected 2", got_dcyc); end
        checks++; if (int'(m_steps) !== 0 || m_pass !== 1'b1) begin errors++; $display("FAIL single_result: got %0d/%b expected 0/1", m_steps, m_pass); end
    endtask

    task automatic test_gaps;
        bit ab;
        int c_steps, c_fails, c_ffs;
        build(9, 35);
        set_bad(4);
        run_trace(1'b0, 0, 1'b0, 1'b0, 0, ab);
        c_steps = int'(m_steps); c_fails = int'(m_fails); c_ffs = int'(m_ffs);
        checks++; if (got_dcyc !== exp_dcyc) begin errors++; $display("FAIL lat0_done_cycle: got %0d expected %0d", got_dcyc, exp_dcyc); end
        checks++; if (c_fails !== exp_fails || c_steps !== exp_steps) begin errors++; $display("FAIL lat0_cont: got %0d/%0d expected %0d/%0d", c_fails, c_steps, exp_fails, exp_steps); end
        run_trace(1'b0, 0, 1'b1, 1'b0, 0, ab);
        checks++;
        if (int'(m_steps) !== c_steps || int'(m_fails) !== c_fails || int'(m_ffs) !== c_ffs || m_pass !== exp_pass) begin
            errors++; $display("FAIL lat0_gaps: got %0d/%0d/%0d expected %0d/%0d/%0d", m_steps, m_fails, m_ffs, c_steps, c_fails, c_ffs);
        end
    endtask

    task automatic test_random;
        bit ab, s, gaps, hold;
        int n, lim;
        for (int it = 0; it < 16; it++) begin
            s    = 1'($urandom_range(1));
            gaps = 1'($urandom_range(1));
            hold = 1'($urandom_range(1));
            n    = $urandom_range(1, 12);
            lim  = ($urandom_range(2) == 0) ? 0 : $urandom_range(1, 12);
            build(n, 40);
            run_trace(s, lim, gaps, hold, 0, ab);
            checks++;
            if (int'(m_steps) !== exp_steps || int'(m_fails) !== exp_fails || m_ffv !== exp_ffv || m_pass !== exp_pass) begin
                errors++; $display("FAIL rand_%0d_stats: got %0d/%0d/%b/%b expected %0d/%0d/%b/%b", it,
                                   m_steps, m_fails, m_ffv, m_pass, exp_steps, exp_fails, exp_ffv, exp_pass);
            end
            checks++;
            if ((exp_ffv && int'(m_ffs) !== exp_first) || got_consumed !== exp_consumed) begin
                errors++; $display("FAIL rand_%0d_first_consumed: got %0d/%0d expected %0d/%0d", it,
                                   m_ffs, got_consumed, exp_first, exp_consumed);
            end
            if (!gaps) begin
                checks++;
                if (got_dcyc !== exp_dcyc) begin errors++; $display("FAIL rand_%0d_cycle: got %0d expected %0d", it, got_dcyc, exp_dcyc); end
            end
        end
    endtask

    task automatic test_saturation;
        bit ab;
        build(300, 100);
        run_trace(1'b0, 0, 1'b0, 1'b0, 0, ab);
        checks++; if (int'(m_fails) !== 255 || int'(m_steps) !== 255) begin errors++; $display("FAIL sat_counts: got %0d/%0d expected 255/255", m_fails, m_steps); end
        checks++; if (int'(m_ffs) !== 0 || m_ffv !== 1'b1 || m_pass !== 1'b0) begin errors++; $display("FAIL sat_first: got %0d/%b/%b expected 0/1/0", m_ffs, m_ffv, m_pass); end
    endtask

    task automatic test_mid_reset;
        bit ab;
        build(8, 0);
        set_bad(2);
        run_trace(1'b1, 0, 1'b0, 1'b0, 3, ab);
        checks++; if (ab !== 1'b1) begin errors++; $display("FAIL midrst_reached: got %b expected 1", ab); end
        start = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        checks++;
        if ({m_in_ready, m_busy, m_done, m_pass, m_ffv} !== 5'b0 || {m_steps, m_fails, m_ffs} !== 24'h0 || m_cur !== '0 || m_nxt !== '0) begin
            errors++; $display("FAIL midrst_outputs: got flags=%b steps=%0d fails=%0d cur=%h expected all 0",
                               {m_in_ready, m_busy, m_done, m_pass, m_ffv}, m_steps, m_fails, m_cur);
        end
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (m_done !== 1'b0 || m_busy !== 1'b0) begin errors++; $display("FAIL midrst_quiet_%0d: got done=%b busy=%b expected 0/0", i, m_done, m_busy); end
        end
        build(5, 30);
        run_trace(1'b1, 0, 1'b0, 1'b0, 0, ab);
        checks++;
        if (int'(m_steps) !== exp_steps || int'(m_fails) !== exp_fails || m_pass !== exp_pass || got_dcyc !== exp_dcyc) begin
            errors++; $display("FAIL midrst_rerun: got %0d/%0d/%b/%0d expected %0d/%0d/%b/%0d",
                               m_steps, m_fails, m_pass, got_dcyc, exp_steps, exp_fails, exp_pass, exp_dcyc);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; sel = 1'b1;
        num_steps = '0; in_state = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_all_pass();
        test_fail_pattern();
        test_step_limit();
        test_single();
        test_gaps();
        test_random();
        test_saturation();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
